// File: rtl/mem_responder.sv
// Byte-addressable big-endian memory answering the MOV/MOC four-phase handshake.
// Requests are captured in IDLE, delayed by WAIT_CYCLES, performed, then acknowledged until MOV drops.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clear,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        Sign,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Error
);

  // state | meaning
  // IDLE  | waiting for MOV, captures the request
  // BUSY  | counting wait states; access performed when counter reaches 0
  // ACK   | MOC held with result until MOV is withdrawn
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_rw, cap_sign;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr, cap_data;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [7:0]  Mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W:0]   last_byte;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic              acc_err;
  logic [31:0]       rd_val;
  logic              do_access;

  assign a0 = cap_addr[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);
  assign do_access = (state == BUSY) && (cnt == 4'd0);

  // Extra MSB of last_byte catches accesses running past the top of the array.
  always_comb begin
    acc_err   = 1'b0;
    last_byte = {1'b0, a0};
    case (cap_size)
      2'b00: acc_err = 1'b0;
      2'b01: begin
        acc_err   = cap_addr[0];
        last_byte = {1'b0, a0} + (ADDR_W+1)'(1);
      end
      2'b10: begin
        acc_err   = |cap_addr[1:0];
        last_byte = {1'b0, a0} + (ADDR_W+1)'(3);
      end
      default: acc_err = 1'b1;
    endcase
    if (last_byte[ADDR_W])    acc_err = 1'b1;
    if (|cap_addr[31:ADDR_W]) acc_err = 1'b1;
  end

  always_comb begin
    case (cap_size)
      2'b00:   rd_val = {{24{cap_sign & Mem[a0][7]}}, Mem[a0]};
      2'b01:   rd_val = {{16{cap_sign & Mem[a0][7]}}, Mem[a0], Mem[a1]};
      default: rd_val = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};
    endcase
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap_rw   <= 1'b0;
      cap_sign <= 1'b0;
      cap_size <= 2'b00;
      cap_addr <= 32'd0;
      cap_data <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (MOV) begin
          cap_rw   <= RW;
          cap_sign <= Sign;
          cap_size <= Size;
          cap_addr <= Address;
          cap_data <= DataIn;
          cnt      <= WAIT_LD;
        end
        BUSY: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          err_q   <= acc_err;
          rdata_q <= (cap_rw && !acc_err) ? rd_val : 32'd0;
        end
        ACK: if (!MOV) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MOV) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = ACK;
      ACK:     if (!MOV) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MOC     = (state == ACK);
    DataOut = rdata_q;
    Error   = err_q;
  end

  // No reset on the array so a preload made while Clear is low survives.
  always @(posedge Clk) begin
    if (Clear && do_access && !cap_rw && !acc_err) begin
      case (cap_size)
        2'b00: Mem[a0] <= cap_data[7:0];
        2'b01: begin
          Mem[a0] <= cap_data[15:8];
          Mem[a1] <= cap_data[7:0];
        end
        default: begin
          Mem[a0] <= cap_data[31:24];
          Mem[a1] <= cap_data[23:16];
          Mem[a2] <= cap_data[15:8];
          Mem[a3] <= cap_data[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected results,
// a monitor pops and compares on every rising MOC.
module tb_mem_responder;

  logic        Clk, Clear, MOV, MOV0, RW, Sign;
  logic [1:0]  Size;
  logic [31:0] Address, DataIn;
  logic [31:0] DataOut, DataOut0;
  logic        MOC, MOC0, Error, Error0;

  int total = 0;
  int bad = 0;
  int rises = 0;
  int pushed = 0;
  logic [31:0] sb_data[$];
  logic        sb_err[$];
  logic [7:0]  ref_mem [0:511];
  logic        moc_prev = 1'b0;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Clear(Clear), .MOV(MOV), .RW(RW), .Size(Size), .Sign(Sign),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC), .Error(Error));

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Clear(Clear), .MOV(MOV0), .RW(RW), .Size(Size), .Sign(Sign),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut0), .MOC(MOC0), .Error(Error0));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  always @(negedge Clk) begin
    if (MOC === 1'b1 && !moc_prev) begin
      rises++;
      if (sb_data.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_moc actual=%h required=none", DataOut);
      end else begin
        logic [31:0] ed;
        logic        ee;
        ed = sb_data.pop_front();
        ee = sb_err.pop_front();
        check("dataout", DataOut, ed);
        check("error", {31'd0, Error}, {31'd0, ee});
      end
    end
    moc_prev = (MOC === 1'b1);
  end

  task automatic preload(input int idx, input logic [7:0] v);
    dut.Mem[idx]  = v;
    dut0.Mem[idx] = v;
    ref_mem[idx]  = v;
  endtask

  task automatic ref_write(input logic [1:0] sz, input int a, input logic [31:0] d);
    case (sz)
      2'b00: ref_mem[a] = d[7:0];
      2'b01: begin ref_mem[a] = d[15:8]; ref_mem[a+1] = d[7:0]; end
      default: begin
        ref_mem[a] = d[31:24]; ref_mem[a+1] = d[23:16];
        ref_mem[a+2] = d[15:8]; ref_mem[a+3] = d[7:0];
      end
    endcase
  endtask

  task automatic check_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < 512; i++)
      if (dut.Mem[i] !== ref_mem[i]) diffs++;
    check(name, 32'(diffs), 32'd0);
  endtask

  task automatic expect_push(input logic [31:0] d, input logic e);
    sb_data.push_back(d);
    sb_err.push_back(e);
    pushed++;
  endtask

  task automatic drive(input logic rw, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    RW = rw; Size = sz; Sign = sg; Address = a; DataIn = d; MOV = 1'b1;
  endtask

  task automatic wait_moc(input logic lvl, output int n);
    n = 0;
    while (MOC !== lvl && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (MOC !== lvl) fail_now(lvl ? "moc_rise" : "moc_fall");
  endtask

  // One full four-phase transaction; inputs are scrambled after capture.
  task automatic do_req(input logic rw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
    int lat, n;
    expect_push(exp_d, exp_e);
    if (!rw && !exp_e) ref_write(sz, int'(a), d);
    drive(rw, sz, sg, a, d);
    @(posedge Clk); #1;
    RW = ~rw; Size = ~sz; Sign = ~sg; Address = ~a; DataIn = ~d;
    wait_moc(1'b1, lat);
    check("latency", 32'(lat), 32'd3);
    MOV = 1'b0;
    wait_moc(1'b0, n);
  endtask

  initial begin
    int lat, n, width, hold_bad, r0;
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, width, hold_bad, r0;
    Clear = 1'b0; MOV = 1'b0; MOV0 = 1'b0; RW = 1'b1; Size = 2'b00; Sign = 1'b0;
    Address = 32'd0; DataIn = 32'd0;
    for (int i = 0; i < 512; i++) preload(i, 8'h00);
    preload(0, 8'h8C); preload(1, 8'h22); preload(2, 8'h00); preload(3, 8'h04);
    preload(4, 8'h80); preload(5, 8'hF0);
    preload(16, 8'h55); preload(17, 8'h66); preload(18, 8'h77); preload(19, 8'h88);
    #12;
    check("reset_moc", {31'd0, MOC}, 32'd0);
    check("reset_dataout", DataOut, 32'd0);
    check("reset_error", {31'd0, Error}, 32'd0);
    @(negedge Clk); Clear = 1'b1;
    check_mem("preload_kept");

    do_req(1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 32'h8C220004, 1'b0);
    do_req(1'b1, 2'b00, 1'b1, 32'd5, 32'd0, 32'hFFFFFFF0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'd5, 32'd0, 32'h000000F0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'd5, 32'h000000_01, 32'd0, 1'b0);
    do_req(1'b1, 2'b01, 1'b1, 32'd4, 32'd0, 32'hFFFF8001, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'd4, 32'd0, 32'h00008001, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h11223344, 32'd0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'd9, 32'h000000AA, 32'd0, 1'b0);
    do_req(1'b1, 2'b10, 1'b1, 32'd8, 32'd0, 32'h11AA3344, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'd10, 32'h0000BEEF, 32'd0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 32'h11AABEEF, 1'b0);

    do_req(1'b1, 2'b10, 1'b0, 32'd2, 32'd0, 32'd0, 1'b1);
    do_req(1'b0, 2'b01, 1'b0, 32'd7, 32'h00001234, 32'd0, 1'b1);
    do_req(1'b1, 2'b11, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'd510, 32'd0, 32'd0, 1'b1);
    do_req(1'b0, 2'b00, 1'b0, 32'h00000208, 32'h000000EE, 32'd0, 1'b1);
    do_req(1'b1, 2'b00, 1'b0, 32'h00000200, 32'd0, 32'd0, 1'b1);
    check_mem("errors_mem");

    // MOV held long after MOC: single access, MOC held until release
    r0 = rises;
    expect_push(32'h8C220004, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 32'd0, 32'd0);
    @(posedge Clk); #1;
    wait_moc(1'b1, lat);
    hold_bad = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (MOC !== 1'b1 || DataOut !== 32'h8C220004) hold_bad++;
    end
    check("hold_moc", 32'(hold_bad), 32'd0);
    MOV = 1'b0;
    @(posedge Clk); #1;
    check("release_moc", {31'd0, MOC}, 32'd0);
    check("single_access", 32'(rises - r0), 32'd1);

    // MOV dropped during BUSY: one-cycle MOC pulse, write still performed
    expect_push(32'd0, 1'b0);
    ref_write(2'b10, 20, 32'h01020304);
    drive(1'b0, 2'b10, 1'b0, 32'd20, 32'h01020304);
    @(posedge Clk); #1;
    MOV = 1'b0;
    wait_moc(1'b1, lat);
    width = 0;
    while (MOC === 1'b1 && width < 20) begin
      width++;
      @(posedge Clk); #1;
    end
    check("pulse_width", 32'(width), 32'd1);
    do_req(1'b1, 2'b10, 1'b0, 32'd20, 32'd0, 32'h01020304, 1'b0);

    // Reset during BUSY drops the write
    drive(1'b0, 2'b10, 1'b0, 32'd16, 32'hDEADBEEF);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Clear = 1'b0;
    #1;
    check("busy_reset_moc", {31'd0, MOC}, 32'd0);
    MOV = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check_mem("busy_reset_mem");
    @(negedge Clk); Clear = 1'b1;
    do_req(1'b1, 2'b10, 1'b0, 32'd16, 32'd0, 32'h55667788, 1'b0);

    // Reset in ACK clears outputs without waiting for a clock
    expect_push(32'h8C220004, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 32'd0, 32'd0);
    @(posedge Clk); #1;
    wait_moc(1'b1, lat);
    @(negedge Clk); #1;
    Clear = 1'b0;
    #1;
    check("ack_reset_moc", {31'd0, MOC}, 32'd0);
    check("ack_reset_dataout", DataOut, 32'd0);
    MOV = 1'b0;
    @(negedge Clk); Clear = 1'b1;

    // Zero wait states
    @(negedge Clk);
    RW = 1'b1; Size = 2'b10; Sign = 1'b0; Address = 32'd0; MOV0 = 1'b1;
    @(posedge Clk); #1;
    lat = 0;
    while (MOC0 !== 1'b1 && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("latency_w0", 32'(lat), 32'd1);
    check("dataout_w0", DataOut0, 32'h8C220004);
    MOV0 = 1'b0;
    @(posedge Clk); #1;
    check("release_w0", {31'd0, MOC0}, 32'd0);

    repeat (3) @(posedge Clk);
    #1;
    check("sb_empty", 32'(sb_data.size()), 32'd0);
    check("moc_count", 32'(rises), 32'(pushed));
    check_mem("final_mem");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-addressable, big-endian memory that answers the datapath's MOV/MOC memory handshake. It is the responder end of the CPU-to-memory interface: it captures a request, waits a programmable number of cycles, then performs the byte, halfword or word read or write. It acknowledges with MOC and holds the acknowledge until the initiator withdraws MOV. The storage array `Mem` is byte-wide and can be preloaded hierarchically, for example `Mem[i] = data`, before the first request.

## Interface
- `ADDR_W`, default 9: byte-address width; the array holds 2^ADDR_W bytes.
- `WAIT_CYCLES`, default 2: wait states inserted before the access, range 0..15.
- `Clk`  in  1: single clock; all state changes on the rising edge.
- `Clear`  in  1: reset, asynchronous, active-low.
- `MOV`  in  1: memory operation valid, driven by the initiator.
- `RW`  in  1: 1 = read, 0 = write.
- `Size`  in  2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `Sign`  in  1: on byte/halfword reads, 1 = sign-extend, 0 = zero-extend.
- `Address`  in  32: byte address.
- `DataIn`  in  32: write data, right-justified.
- `DataOut`  out  32: read data, valid while MOC = 1.
- `MOC`  out  1: memory operation complete.
- `Error`  out  1: request rejected; valid while MOC = 1.

## Operation
- The block has three states:
  - IDLE
    - When MOV = 1 is sampled, capture RW, Size, Sign, Address and DataIn.
    - Load the counter with WAIT_CYCLES and go to BUSY.
  - BUSY
    - If counter ≠ 0, decrement the counter.
    - If counter = 0, perform the access, set MOC = 1 and go to ACK.
  - ACK
    - Hold MOC, DataOut and Error.
    - When MOV = 0 is sampled, clear MOC, DataOut and Error and go to IDLE.
- The block uses only the captured values; input changes after capture are ignored.
- Byte order is big-endian:
  - A word at A occupies Mem[A] = bits 31:24 through Mem[A+3] = bits 7:0.
  - A halfword at A occupies Mem[A] = bits 15:8 and Mem[A+1] = bits 7:0.
- Reads:
  - A byte or halfword is placed in the low bits of DataOut.
  - The upper bits are filled with copies of the MSB when Sign = 1, and with 0 otherwise.
  - A word read ignores Sign.
- Writes:
  - DataIn[7:0] is written for a byte, DataIn[15:0] for a halfword, DataIn[31:0] for a word.
  - Bytes outside the access size are untouched.
  - DataOut = 0 on writes.
- Error = 1 in any of these cases:
  - Size = 11.
  - A halfword with Address[0] = 1.
  - A word with Address[1:0] ≠ 00.
  - Address + bytes − 1 ≥ 2^ADDR_W.
  - Upper address bits nonzero.
- On an error the block still completes the handshake normally. Memory is unchanged and DataOut = 0.

## Timing
- Reset (Clear = 0):
  - Takes effect immediately, independent of Clk.
  - State = IDLE, MOC = 0, DataOut = 0, Error = 0, counter = 0.
  - Mem contents are not altered, so a preload done during reset survives.
- Reset mid-operation: any request in BUSY is dropped with no memory write. A request already in ACK has already been performed.
- Latency: MOV is sampled high at edge k, so MOC = 1 after edge k + WAIT_CYCLES + 1.
  - WAIT_CYCLES = 0 gives MOC after edge k+1.
- Memory write timing: Mem is written on the same edge at which MOC rises, so a read issued next observes the new data.
- Release: in ACK, MOV sampled low at edge m gives MOC = 0 after edge m. The earliest next capture is edge m+1.
- MOV that stays high across ACK never starts a second operation. The initiator must drop MOV (four-phase handshake).
- MOV dropped during BUSY: the captured request still completes. MOC is high for exactly one cycle, then clears because MOV = 0.
- Back-to-back requests: the minimum request spacing is WAIT_CYCLES + 3 edges.

## Test plan
- Preload and word read:
  - Stimulus: preload Mem[0..3] = 8C, 22, 00, 04 with Clear low, release reset, then read word @0 with WAIT_CYCLES = 2.
  - Required: DataOut = 32'h8C220004 and MOC rising 3 edges after capture.
- Sub-word signed/unsigned reads:
  - Stimulus: Mem[5] = 8'hF0. Read byte @5 with Sign = 1, then with Sign = 0.
  - Required: 32'hFFFFFFF0, then 32'h000000F0.
  - Stimulus: read halfword @4 where Mem[4..5] = 80, 01, with Sign = 1.
  - Required: 32'hFFFF8001.
- Writes by size:
  - Stimulus: write word 32'h11223344 @8, then byte 8'hAA @9, then read word @8.
  - Required: 32'h11AA3344.
  - Stimulus: write halfword 16'hBEEF @10, then read word @8.
  - Required: 32'h11AABEEF.
- Errors:
  - Stimulus: word read @2, halfword write @7, Size = 11, and word @ 2^ADDR_W − 2.
  - Required for each: MOC = 1, Error = 1, DataOut = 0, and memory checksum unchanged.
- Handshake edges:
  - Hold MOV high for 10 cycles after MOC: exactly one access occurs and MOC stays high until MOV falls.
  - Drop MOV one cycle after capture: a one-cycle MOC pulse occurs and the write is performed.
  - Set WAIT_CYCLES = 0: MOC appears 1 edge after capture.
- Reset mid-operation:
  - Stimulus: assert Clear low during BUSY of a write of 32'hDEADBEEF @16.
  - Required: MOC = 0 immediately, Mem[16..19] unchanged, and the next request after reset serviced normally.
